// File: rtl/frequency_divider_bank.sv
// Bank of independent 50%-duty clock dividers with double-buffered divisors.
// Optional FREQDIV_SYNC_EN adds a 'sync' input that phase-aligns every channel.
module frequency_divider_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32
) (
    input  logic                      clock_in,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] divisor,
`ifdef FREQDIV_SYNC_EN
    input  logic                      sync,
`endif
    output logic [CHANNELS-1:0]       clock_out,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       pending
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] r_act;
        logic [WIDTH-1:0] r_pendVal;
        logic             r_pend;
        logic             r_clk;
        logic             r_tick;
        logic [WIDTH-1:0] w_div;
        logic             w_last;

        assign w_div  = divisor[i*WIDTH +: WIDTH];
        assign w_last = enable[i] && (r_act != '0) && (r_cnt == r_act - WIDTH'(1));

        always_ff @(posedge clock_in) begin
            if (reset) begin
                r_cnt     <= '0;
                r_act     <= '0;
                r_pendVal <= '0;
                r_pend    <= 1'b0;
                r_clk     <= 1'b0;
                r_tick    <= 1'b0;
            end
`ifdef FREQDIV_SYNC_EN
            else if (sync) begin
                if (r_pend) begin
                    r_act  <= r_pendVal;
                    r_pend <= 1'b0;
                end
                r_cnt  <= '0;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end
`endif
            else begin
                r_tick <= 1'b0;
                if (r_act == '0) begin
                    // An idle channel takes a new divisor immediately and starts in its low phase.
                    if (load[i]) begin
                        r_act <= w_div;
                        r_cnt <= '0;
                    end
                end else if (w_last) begin
                    r_cnt <= '0;
                    if (r_clk) begin
                        r_clk <= 1'b0;
                        if (load[i]) begin
                            r_act  <= w_div;
                            r_pend <= 1'b0;
                        end else if (r_pend) begin
                            r_act  <= r_pendVal;
                            r_pend <= 1'b0;
                        end
                    end else begin
                        r_clk  <= 1'b1;
                        r_tick <= 1'b1;
                        if (load[i]) begin
                            r_pendVal <= w_div;
                            r_pend    <= 1'b1;
                        end
                    end
                end else begin
                    if (enable[i]) begin
                        r_cnt <= r_cnt + WIDTH'(1);
                    end
                    if (load[i]) begin
                        r_pendVal <= w_div;
                        r_pend    <= 1'b1;
                    end
                end
            end
        end

        assign clock_out[i] = r_clk;
        assign tick[i]      = r_tick;
        assign pending[i]   = r_pend;
    end

endmodule

// File: tb/tb_frequency_divider_bank.sv
// Directed self-checking bench for frequency_divider_bank (4 channels, 8-bit divisors).
// The sync scenario is built only when FREQDIV_SYNC_EN is defined.
module tb_frequency_divider_bank;
    localparam int CH = 4;
    localparam int W  = 8;

    logic              clock_in = 1'b0;
    logic              reset;
    logic              sync;
    logic [CH-1:0]     enable;
    logic [CH-1:0]     load;
    logic [CH*W-1:0]   divisor;
    logic [CH-1:0]     clock_out;
    logic [CH-1:0]     tick;
    logic [CH-1:0]     pending;
    logic [CH-1:0]     expCo;
    logic [CH-1:0]     expTk;
    int                errorCount = 0;
    int                checkCount = 0;

    always #5 clock_in = ~clock_in;

    frequency_divider_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .divisor   (divisor),
`ifdef FREQDIV_SYNC_EN
        .sync      (sync),
`endif
        .clock_out (clock_out),
        .tick      (tick),
        .pending   (pending)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic applyStimulus(input int ch, input logic [W-1:0] n);
        load[ch]              = 1'b1;
        divisor[ch*W +: W]    = n;
    endtask

    task automatic doReset();
        reset   = 1'b1;
        load    = '0;
        divisor = '0;
        step();
        reset   = 1'b0;
    endtask

    // Closed-form reference: after loading N at edge 0, the output is high on edges [N,2N), [3N,4N), ...
    function automatic logic expHigh(input int k, input int n);
        return ((k / n) % 2) == 1;
    endfunction

    function automatic logic expTick(input int k, input int n);
        return (k >= n) && ((k % (2 * n)) == n);
    endfunction

    initial begin
        reset   = 1'b1;
        sync    = 1'b0;
        enable  = '0;
        load    = '0;
        divisor = '0;
        step();
        step();
        checkOutput("rstClk",  clock_out, 4'h0);
        checkOutput("rstTick", tick,      4'h0);
        checkOutput("rstPend", pending,   4'h0);
        reset  = 1'b0;
        enable = 4'hF;

        applyStimulus(0, 8'd1);
        step();
        load = '0;
        checkOutput("n1Load", clock_out, 4'h0);
        for (int k = 1; k <= 6; k++) begin
            step();
            checkOutput("n1Clk",  32'(clock_out[0]), 32'(k % 2));
            checkOutput("n1Tick", 32'(tick[0]),      32'(k % 2));
        end

        doReset();
        applyStimulus(0, 8'd2);
        applyStimulus(1, 8'd8);
        applyStimulus(2, 8'd32);
        step();
        load = '0;
        for (int k = 1; k <= 128; k++) begin
            step();
            expCo = {1'b0, expHigh(k, 32), expHigh(k, 8), expHigh(k, 2)};
            expTk = {1'b0, expTick(k, 32), expTick(k, 8), expTick(k, 2)};
            checkOutput("multiClk",  32'(clock_out), 32'(expCo));
            checkOutput("multiTick", 32'(tick),      32'(expTk));
        end

        // Switch ch1 from 8 to 3 in the middle of its first high phase.
        doReset();
        applyStimulus(1, 8'd8);
        step();
        load = '0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 11) applyStimulus(1, 8'd3);
            step();
            load = '0;
            checkOutput("swClk",  32'(clock_out[1]),
                        32'((k < 16) ? expHigh(k, 8) : expHigh(k - 16, 3)));
            checkOutput("swTick", 32'(tick[1]),
                        32'((k == 8) || (k >= 16 && ((k - 16) % 6) == 3)));
            checkOutput("swPend", 32'(pending[1]), 32'(k >= 11 && k < 16));
        end

        // Freeze ch0 (N=4) for edges 6..10 while it is high with cnt=1.
        doReset();
        applyStimulus(0, 8'd4);
        step();
        load = '0;
        for (int k = 1; k <= 22; k++) begin
            enable[0] = !(k >= 6 && k <= 10);
            step();
            checkOutput("enClk",  32'(clock_out[0]),
                        32'((k >= 4 && k < 13) || (k >= 17 && k < 21)));
            checkOutput("enTick", 32'(tick[0]), 32'(k == 4 || k == 17));
        end
        enable = 4'hF;

        doReset();
        applyStimulus(0, 8'd3);
        applyStimulus(1, 8'd5);
        applyStimulus(2, 8'd2);
        applyStimulus(3, 8'd7);
        step();
        load = '0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) applyStimulus(1, 8'd4);
            step();
            load = '0;
        end
        checkOutput("midPend", pending, 4'b0010);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("midRstClk",  clock_out, 4'h0);
        checkOutput("midRstTick", tick,      4'h0);
        checkOutput("midRstPend", pending,   4'h0);
        for (int k = 1; k <= 12; k++) begin
            step();
            checkOutput("stopClk",  clock_out, 4'h0);
            checkOutput("stopTick", tick,      4'h0);
            checkOutput("stopPend", pending,   4'h0);
        end

        // Load on a boundary edge (applied directly), then a pending zero that stops the channel.
        doReset();
        applyStimulus(0, 8'd2);
        step();
        load = '0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) applyStimulus(0, 8'd1);
            if (k == 7) applyStimulus(0, 8'd0);
            step();
            load = '0;
            checkOutput("bndClk", 32'(clock_out[0]),
                        32'((k >= 2 && k < 4) || (k >= 4 && k < 8 && ((k - 4) % 2) == 1)));
            checkOutput("bndTick", 32'(tick[0]), 32'(k == 2 || k == 5 || k == 7));
            checkOutput("bndPend", 32'(pending[0]), 32'(k == 7));
        end

        doReset();
        applyStimulus(2, 8'd255);
        step();
        load = '0;
        for (int k = 1; k <= 254; k++) step();
        checkOutput("maxLow", 32'(clock_out[2]), 32'd0);
        step();
        checkOutput("maxRise", 32'(clock_out[2]), 32'd1);
        checkOutput("maxTick", 32'(tick[2]),      32'd1);
        for (int k = 1; k <= 254; k++) step();
        checkOutput("maxHigh", 32'(clock_out[2]), 32'd1);
        step();
        checkOutput("maxFall", 32'(clock_out[2]), 32'd0);
        checkOutput("maxNoTick", 32'(tick[2]),    32'd0);

`ifdef FREQDIV_SYNC_EN
        doReset();
        applyStimulus(0, 8'd4);
        step();
        load = '0;
        step();
        step();
        applyStimulus(1, 8'd4);
        step();
        load = '0;
        step();
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        checkOutput("syncClk",  32'(clock_out[1:0]), 32'd0);
        checkOutput("syncTick", 32'(tick[1:0]),      32'd0);
        for (int j = 1; j <= 10; j++) begin
            step();
            checkOutput("alignClk",  32'(clock_out[1:0]), expHigh(j, 4) ? 32'd3 : 32'd0);
            checkOutput("alignTick", 32'(tick[1:0]),      (j == 4) ? 32'd3 : 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
